// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid-buffer variant with a registered o_ready.
module pipe_stage_reg #(
  parameter int                 NB_DATA   = 32,
  parameter logic [NB_DATA-1:0] RESET_VAL = {NB_DATA{1'b0}},
  parameter int                 NB_CNT    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  input  logic               i_clr_cnt,
  output logic [NB_CNT-1:0]  o_stall_cnt
);

  logic              valid_q;
  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;
  logic              stall_s;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [NB_DATA-1:0] main_q;
  logic [NB_DATA-1:0] main_d;
  logic [NB_DATA-1:0] skid_q;
  logic [NB_DATA-1:0] skid_d;
  logic               ready_q;
  logic               in_s;
  logic               out_s;

  assign in_s    = i_valid && ready_q;
  assign out_s   = i_ready && valid_q;
  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = main_q;

  // Next-state and data steering for the main/skid pair
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_s) begin
            state_d = ST_ONE;
            main_d  = i_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_s && out_s) begin
            main_d = i_data;
          end else if (in_s && !out_s) begin
            state_d = ST_TWO;
            skid_d  = i_data;
          end else if (!in_s && out_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // Downstream drains main; the skid entry moves up to keep FIFO order
          if (out_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // FSM state, payload registers and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_TWO);
      valid_q <= (state_d != ST_EMPTY);
    end
  end

`else

  logic               valid_d;
  logic [NB_DATA-1:0] data_q;
  logic [NB_DATA-1:0] data_d;
  logic               in_hs_s;

  assign o_ready = !valid_q || i_ready;
  assign in_hs_s = i_valid && o_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  // Single-register capture; a flush drops the entry and discards any incoming payload
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (in_hs_s) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage payload registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

  assign stall_s     = valid_q && !i_ready;
  assign o_stall_cnt = cnt_q;

  // Saturating stall counter; clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_cnt) begin
      cnt_d = {NB_CNT{1'b0}};
    end else if (stall_s && (cnt_q != {NB_CNT{1'b1}})) begin
      cnt_d = cnt_q + {{(NB_CNT-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= {NB_CNT{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stimulus pushes expected payloads,
// a negedge monitor pops and compares on every output handshake.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b1;
  logic [31:0] i_data  = 32'hA5A5_A5A5;
  logic        i_ready = 1'b0;
  logic        i_clr_cnt = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic [15:0] o_stall_cnt;

  logic        v3 = 1'b0;
  logic        r3 = 1'b0;
  logic [31:0] d3 = 32'h0;
  logic        clr3 = 1'b0;
  logic        f3 = 1'b0;
  logic        rdy3;
  logic        val3;
  logic [31:0] dat3;
  logic [2:0]  cnt3;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  pipe_stage_reg #(.NB_DATA(32), .RESET_VAL(32'h0), .NB_CNT(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .i_clr_cnt(i_clr_cnt), .o_stall_cnt(o_stall_cnt)
  );

  pipe_stage_reg #(.NB_DATA(32), .RESET_VAL(32'h0), .NB_CNT(3)) dut3 (
    .i_clk(clk), .i_reset(i_reset), .i_flush(f3), .i_valid(v3),
    .o_ready(rdy3), .i_data(d3), .o_valid(val3), .i_ready(r3),
    .o_data(dat3), .i_clr_cnt(clr3), .o_stall_cnt(cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one payload and hold it until the stage accepts it (bounded)
  task automatic send(input logic [31:0] v);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_data  = v;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    chk("send_accept", {31'b0, acc}, 32'h1);
  endtask

  // Monitor: every output handshake must match the head of the expected queue
  always @(negedge clk) begin
    if (!i_reset && !i_flush && o_valid && i_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got %h, required no output", o_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (o_data !== exp_v) begin
          fails++;
          $display("FAIL out_data: got %h, required %h", o_data, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles with a live input that must not be captured
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'b0, o_valid}, 32'h0);
      chk("rst_data", o_data, 32'h0);
      chk("rst_cnt", {16'b0, o_stall_cnt}, 32'h0);
      chk("rst_cnt3", {29'b0, cnt3}, 32'h0);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, o_valid}, 32'h0);

    // Streaming 1..8 with downstream always ready
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      i_valid = 1'b1;
      i_data  = k;
      exp_q.push_back(k);
      @(negedge clk);
      chk("stream_ready", {31'b0, o_ready}, 32'h1);
      chk("stream_valid", {31'b0, o_valid}, (k > 1) ? 32'h1 : 32'h0);
      if (k > 1) chk("stream_data", o_data, k - 1);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", o_data, 32'h8);
    chk("stream_last_v", {31'b0, o_valid}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: 0x11, 0x22, 0x33 against four stalled cycles
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h33);
    fork
      begin
        send(32'h11);
        send(32'h22);
        send(32'h33);
      end
      begin
        i_ready   = 1'b0;
        i_clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        i_clr_cnt = 1'b0;
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_ready_c1", {31'b0, o_ready}, 32'h1);
`else
        chk("bp_ready_c1", {31'b0, o_ready}, 32'h0);
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_c2", {31'b0, o_ready}, 32'h0);
        chk("bp_hold_data", o_data, 32'h11);
        chk("bp_hold_valid", {31'b0, o_valid}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_stall_cnt", {16'b0, o_stall_cnt}, 32'h4);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 32'h0);

    // Flush with a simultaneous input: 0x66 is killed, 0x77 discarded
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h66;
    @(posedge clk);
    #1;
    i_flush = 1'b1;
    i_ready = 1'b1;
    i_data  = 32'h77;
    @(negedge clk);
    chk("flush_pre_valid", {31'b0, o_valid}, 32'h1);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'b0, o_valid}, 32'h0);
    chk("flush_data_kept", o_data, 32'h66);
    repeat (3) @(posedge clk);
    #1;

    // Saturation on the 3-bit counter instance
    v3 = 1'b1;
    d3 = 32'h5;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_cnt", {29'b0, cnt3}, 32'h7);
    chk("sat_data", dat3, 32'h5);
    @(posedge clk);
    #1;
    clr3 = 1'b1;
    @(posedge clk);
    #1;
    clr3 = 1'b0;
    @(negedge clk);
    chk("clr_cnt", {29'b0, cnt3}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("clr_resume", {29'b0, cnt3}, 32'h1);

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
